calculator_core: RTL and testbench

- Registered 8-operation integer calculator on two unsigned 4-bit operands, selected by a 3-bit opcode.
- Result is zero-extended or full-width into an 8-bit output.
- Used as a small datapath/ALU leaf block.
- One-cycle latency, with a valid strobe and a divide-by-zero error flag.

---
 rtl/calculator_core.sv | 96 +++++++++
 tb/tb_calculator_core.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/calculator_core.sv
// calculator_core: registered 8-operation unsigned calculator with a one-cycle
// latency, a valid strobe and a divide-by-zero error flag.
module calculator_core #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [2:0]           oper,
    output logic [2*WIDTH-1:0]   out,
    output logic                 out_valid,
    output logic                 err
);

    localparam int unsigned RW = 2 * WIDTH;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_MOD = 3'b100;
    localparam logic [2:0] OP_AND = 3'b101;
    localparam logic [2:0] OP_OR  = 3'b110;
    localparam logic [2:0] OP_XOR = 3'b111;

    logic [RW-1:0] w_a_ext;
    logic [RW-1:0] w_b_ext;
    logic          w_b_zero;
    logic [RW-1:0] w_result;
    logic          w_err;

    logic [RW-1:0] r_out;
    logic          r_out_valid;
    logic          r_err;

    // Operands are zero-extended to the result width before any operation.
    assign w_a_ext  = RW'(a);
    assign w_b_ext  = RW'(b);
    assign w_b_zero = (b == '0);

    // Combinational datapath; a zero divisor never reaches the divider.
    always_comb begin
        w_result = '0;
        w_err    = 1'b0;
        case (oper)
            OP_ADD: w_result = w_a_ext + w_b_ext;
            OP_SUB: w_result = w_a_ext - w_b_ext;
            OP_MUL: w_result = w_a_ext * w_b_ext;
            OP_DIV: begin
                if (w_b_zero) begin
                    w_result = '1;
                    w_err    = 1'b1;
                end else begin
                    w_result = w_a_ext / w_b_ext;
                end
            end
            OP_MOD: begin
                if (w_b_zero) begin
                    w_result = '1;
                    w_err    = 1'b1;
                end else begin
                    w_result = w_a_ext % w_b_ext;
                end
            end
            OP_AND: w_result = w_a_ext & w_b_ext;
            OP_OR:  w_result = w_a_ext | w_b_ext;
            OP_XOR: w_result = w_a_ext ^ w_b_ext;
            default: begin
                w_result = '0;
                w_err    = 1'b0;
            end
        endcase
    end

    // Result register: captures on accepted input, holds otherwise; reset wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_out <= w_result;
                r_err <= w_err;
            end
        end
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign err       = r_err;

endmodule

// File: tb/tb_calculator_core.sv
// tb_calculator_core: directed and randomized checks of calculator_core against
// an arithmetic reference model.
module tb_calculator_core;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] oper;
    logic [7:0] out;
    logic       out_valid;
    logic       err;

    int n_checks;
    int n_fail;

    // Expected output state maintained by the model.
    logic [7:0] exp_out;
    logic       exp_valid;
    logic       exp_err;

    calculator_core #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .oper      (oper),
        .out       (out),
        .out_valid (out_valid),
        .err       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, expv, $time);
        end
    endtask

    // Reference: plain integer arithmetic reduced modulo 256; bit 8 is err.
    function automatic logic [8:0] ref_calc(input int ua, input int ub, input int op);
        int r;
        logic e;
        e = 1'b0;
        r = 0;
        case (op)
            0: r = ua + ub;
            1: r = ua - ub;
            2: r = ua * ub;
            3: if (ub == 0) begin r = 255; e = 1'b1; end else r = ua / ub;
            4: if (ub == 0) begin r = 255; e = 1'b1; end else r = ua % ub;
            5: r = ua & ub;
            6: r = ua | ub;
            7: r = ua ^ ub;
            default: r = 0;
        endcase
        r = r & 255;
        return {e, r[7:0]};
    endfunction

    // Apply one cycle of inputs, advance the model, and compare after the edge.
    task automatic step(input logic r, input logic v, input int ua, input int ub, input int op,
                        input string tag);
        logic [8:0] m;
        rst      = r;
        in_valid = v;
        a        = 4'(ua);
        b        = 4'(ub);
        oper     = 3'(op);
        @(posedge clk);
        #1;
        if (r) begin
            exp_out   = 8'h00;
            exp_valid = 1'b0;
            exp_err   = 1'b0;
        end else begin
            exp_valid = v;
            if (v) begin
                m       = ref_calc(ua, ub, op);
                exp_out = m[7:0];
                exp_err = m[8];
            end
        end
        check({tag, ".out"}, 32'(out), 32'(exp_out));
        check({tag, ".valid"}, 32'(out_valid), 32'(exp_valid));
        check({tag, ".err"}, 32'(err), 32'(exp_err));
    endtask

    logic [7:0] sweep_exp [8];

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        exp_out   = 8'h00;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        rst       = 1'b1;
        in_valid  = 1'b1;
        a         = 4'd0;
        b         = 4'd0;
        oper      = 3'd0;

        sweep_exp[0] = 8'b00001100;
        sweep_exp[1] = 8'b00000110;
        sweep_exp[2] = 8'b00011011;
        sweep_exp[3] = 8'b00000011;
        sweep_exp[4] = 8'b00000000;
        sweep_exp[5] = 8'b00000001;
        sweep_exp[6] = 8'b00001011;
        sweep_exp[7] = 8'b00001010;

        // Reset held two cycles with in_valid asserted, then one idle cycle.
        step(1'b1, 1'b1, 9, 3, 0, "rst0");
        step(1'b1, 1'b1, 15, 15, 2, "rst1");
        step(1'b0, 1'b0, 15, 15, 2, "post_rst");
        check("post_rst.out_const", 32'(out), 32'h00);

        // Opcode sweep with a=9, b=3.
        for (int op = 0; op < 8; op++) begin
            step(1'b0, 1'b1, 9, 3, op, "sweep");
            check($sformatf("sweep_op%0d", op), 32'(out), 32'(sweep_exp[op]));
            check($sformatf("sweep_op%0d.valid", op), 32'(out_valid), 32'd1);
        end

        // Wrap and extremes.
        step(1'b0, 1'b1, 3, 9, 1, "sub_wrap");
        check("sub_wrap_const", 32'(out), 32'hFA);
        step(1'b0, 1'b1, 15, 15, 2, "mul_max");
        check("mul_max_const", 32'(out), 32'hE1);
        step(1'b0, 1'b1, 15, 15, 0, "add_max");
        check("add_max_const", 32'(out), 32'h1E);
        step(1'b0, 1'b1, 0, 0, 7, "xor_zero");
        check("xor_zero_const", 32'(out), 32'h00);

        // Divide by zero, then a normal divide clears err.
        step(1'b0, 1'b1, 7, 0, 3, "div0");
        check("div0_const", 32'({err, out}), 32'h1FF);
        step(1'b0, 1'b1, 7, 0, 4, "mod0");
        check("mod0_const", 32'({err, out}), 32'h1FF);
        step(1'b0, 1'b1, 7, 2, 3, "div_ok");
        check("div_ok_const", 32'({err, out}), 32'h003);

        // Valid gating: one ADD then three idle cycles with changing inputs.
        step(1'b0, 1'b1, 5, 6, 0, "gate_add");
        check("gate_add_const", 32'(out), 32'h0B);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, i + 1, 7 - i, i + 2, "gate_idle");
            check("gate_idle_hold", 32'({out_valid, out}), 32'h00B);
        end

        // Reset asserted on the same edge as an accepted input.
        step(1'b0, 1'b1, 12, 3, 2, "pre_midrst");
        step(1'b1, 1'b1, 12, 3, 2, "midrst");
        check("midrst_const", 32'({out_valid, out}), 32'h000);
        step(1'b0, 1'b0, 1, 1, 0, "after_midrst");
        check("after_midrst_const", 32'({out_valid, out}), 32'h000);

        // Randomized traffic with occasional reset, idle cycles and zero divisors.
        for (int i = 0; i < 400; i++) begin
            logic rr;
            logic vv;
            int   ra;
            int   rb;
            rr = ($urandom_range(0, 29) == 0);
            vv = ($urandom_range(0, 3) != 0);
            ra = int'($urandom_range(0, 15));
            rb = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(0, 15));
            step(rr, vv, ra, rb, int'($urandom_range(0, 7)), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
